// File: rtl/riscv_pipe_pkg.sv
// Shared types and constants for the 5-stage pipeline control path.
package riscv_pipe_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    FLUSH    = 2'd1,
    MEM_WAIT = 2'd2,
    HALT     = 2'd3
  } hazard_state_t;

  localparam logic [31:0] NOP_INSTR = 32'h00000013;
  localparam int          PERF_W    = 32;

  function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] value);
    return (&value) ? value : value + 1'b1;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// Load-use compare between the ID source registers and a load in EX; x0 never hazards.
// Purely combinational, no backpressure.
module load_use_detect (
  input  logic [4:0] id_rs1,
  input  logic [4:0] id_rs2,
  input  logic       id_uses_rs2,
  input  logic [4:0] ex_rd,
  input  logic       ex_mem_read,
  output logic       load_use
);

  logic rs1_hit;
  logic rs2_hit;

  assign rs1_hit  = (ex_rd == id_rs1);
  assign rs2_hit  = id_uses_rs2 & (ex_rd == id_rs2);
  assign load_use = ex_mem_read & (ex_rd != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush sequencer: outputs decode state and inputs in the same cycle; dmem not-ready freezes the pipe.
// Optional perf counters when HAZARD_PERF_EN is defined.
module pipeline_hazard_ctrl
  import riscv_pipe_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int MEM_TIMEOUT  = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [4:0]        id_rs1,
  input  logic [4:0]        id_rs2,
  input  logic              id_uses_rs2,
  input  logic [4:0]        ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_redirect,
  input  logic              dmem_req,
  input  logic              dmem_ready,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              if_id_flush,
  output logic              id_ex_bubble,
  output logic              ex_mem_hold,
  output logic              mem_timeout
`ifdef HAZARD_PERF_EN
  ,
  output logic [PERF_W-1:0] perf_load_stalls,
  output logic [PERF_W-1:0] perf_flush_cycles,
  output logic [PERF_W-1:0] perf_mem_wait_cycles
`endif
);

  localparam int             FC_W    = (FLUSH_CYCLES < 1) ? 1 : $clog2(FLUSH_CYCLES + 1);
  localparam logic [FC_W-1:0] FC_INIT = FC_W'(FLUSH_CYCLES);
  localparam logic [FC_W-1:0] FC_ONE  = FC_W'(1);
  localparam logic [3:0]      TO_LIM  = 4'(MEM_TIMEOUT);

  hazard_state_t   state, state_n;
  logic [3:0]      wait_cnt, wait_n;
  logic [FC_W-1:0] flush_cnt, flush_n;
  logic            redir_pend, pend_n;
  logic            load_use;
  logic            mem_stall;
  logic            run_dec;
  logic            flush_dec;
  logic            redir_eff;

  load_use_detect u_load_use (
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_uses_rs2 (id_uses_rs2),
    .ex_rd       (ex_rd),
    .ex_mem_read (ex_mem_read),
    .load_use    (load_use)
  );

  assign mem_stall = dmem_req & ~dmem_ready;
  // A redirect held in EX across a memory wait is replayed on the ready cycle.
  assign redir_eff = ex_redirect | ((state == MEM_WAIT) & redir_pend);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= RUN;
      wait_cnt   <= '0;
      flush_cnt  <= '0;
      redir_pend <= 1'b0;
    end else begin
      state      <= state_n;
      wait_cnt   <= wait_n;
      flush_cnt  <= flush_n;
      redir_pend <= pend_n;
    end
  end

  always_comb begin
    state_n        = state;
    wait_n         = wait_cnt;
    flush_n        = flush_cnt;
    pend_n         = 1'b0;
    run_dec        = 1'b0;
    flush_dec      = 1'b0;
    pc_write_en    = 1'b0;
    if_id_write_en = 1'b0;
    if_id_flush    = 1'b0;
    id_ex_bubble   = 1'b0;
    ex_mem_hold    = 1'b0;

    unique case (state)
      RUN: begin
        if (mem_stall) begin
          ex_mem_hold = 1'b1;
          state_n     = MEM_WAIT;
          wait_n      = 4'd1;
          pend_n      = ex_redirect;
        end else begin
          run_dec = 1'b1;
        end
      end
      FLUSH: begin
        if (mem_stall) begin
          ex_mem_hold = 1'b1;
          state_n     = MEM_WAIT;
          wait_n      = 4'd1;
        end else begin
          flush_dec = 1'b1;
        end
      end
      MEM_WAIT: begin
        if (dmem_ready) begin
          wait_n = '0;
          // A non-zero flush count means the wait interrupted a FLUSH sequence.
          if (flush_cnt != '0) flush_dec = 1'b1;
          else                 run_dec   = 1'b1;
        end else if (wait_cnt == TO_LIM) begin
          ex_mem_hold = 1'b1;
          state_n     = HALT;
        end else begin
          ex_mem_hold = 1'b1;
          wait_n      = wait_cnt + 4'd1;
          pend_n      = redir_pend | (ex_redirect & (flush_cnt == '0));
        end
      end
      HALT: begin
        ex_mem_hold = 1'b1;
      end
      default: state_n = RUN;
    endcase

    if (run_dec) begin
      state_n = RUN;
      if (redir_eff) begin
        pc_write_en  = 1'b1;
        if_id_flush  = 1'b1;
        id_ex_bubble = 1'b1;
        if (FLUSH_CYCLES > 0) begin
          state_n = FLUSH;
          flush_n = FC_INIT;
        end
      end else if (load_use) begin
        id_ex_bubble = 1'b1;
      end else begin
        pc_write_en    = 1'b1;
        if_id_write_en = 1'b1;
      end
    end

    if (flush_dec) begin
      pc_write_en  = 1'b1;
      if_id_flush  = 1'b1;
      id_ex_bubble = 1'b1;
      flush_n      = flush_cnt - FC_ONE;
      state_n      = (flush_cnt == FC_ONE) ? RUN : FLUSH;
    end

    if (reset) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      if_id_flush    = 1'b1;
      id_ex_bubble   = 1'b1;
      ex_mem_hold    = 1'b0;
    end
  end

  assign mem_timeout = (state == HALT) & ~reset;

`ifdef HAZARD_PERF_EN
  logic lu_stall_cyc;

  // Only a load-use stall produces a bubble without flush and with the PC held.
  assign lu_stall_cyc = id_ex_bubble & ~if_id_flush & ~pc_write_en;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_load_stalls     <= '0;
      perf_flush_cycles    <= '0;
      perf_mem_wait_cycles <= '0;
    end else begin
      if (lu_stall_cyc)       perf_load_stalls     <= sat_inc(perf_load_stalls);
      if (if_id_flush)        perf_flush_cycles    <= sat_inc(perf_flush_cycles);
      if (state == MEM_WAIT)  perf_mem_wait_cycles <= sat_inc(perf_mem_wait_cycles);
    end
  end
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl (FLUSH_CYCLES=1, MEM_TIMEOUT=15); outputs packed as {pc,ifwe,flush,bubble,hold,timeout}.
module tb_pipeline_hazard_ctrl;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [4:0] id_rs1, id_rs2, ex_rd;
  logic       id_uses_rs2, ex_mem_read, ex_redirect, dmem_req, dmem_ready;
  logic       pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold, mem_timeout;
  logic [5:0] outs;
`ifdef HAZARD_PERF_EN
  logic [31:0] perf_load_stalls, perf_flush_cycles, perf_mem_wait_cycles;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  localparam logic [5:0] O_RST    = 6'b001100;
  localparam logic [5:0] O_RUN    = 6'b110000;
  localparam logic [5:0] O_STALL  = 6'b000100;
  localparam logic [5:0] O_FLUSH  = 6'b101100;
  localparam logic [5:0] O_FREEZE = 6'b000010;
  localparam logic [5:0] O_HALT   = 6'b000011;

  always #5 clk = ~clk;

  assign outs = {pc_write_en, if_id_write_en, if_id_flush, id_ex_bubble, ex_mem_hold, mem_timeout};

  pipeline_hazard_ctrl #(.FLUSH_CYCLES(1), .MEM_TIMEOUT(15)) dut (
    .clk            (clk),
    .reset          (reset),
    .id_rs1         (id_rs1),
    .id_rs2         (id_rs2),
    .id_uses_rs2    (id_uses_rs2),
    .ex_rd          (ex_rd),
    .ex_mem_read    (ex_mem_read),
    .ex_redirect    (ex_redirect),
    .dmem_req       (dmem_req),
    .dmem_ready     (dmem_ready),
    .pc_write_en    (pc_write_en),
    .if_id_write_en (if_id_write_en),
    .if_id_flush    (if_id_flush),
    .id_ex_bubble   (id_ex_bubble),
    .ex_mem_hold    (ex_mem_hold),
    .mem_timeout    (mem_timeout)
`ifdef HAZARD_PERF_EN
    ,
    .perf_load_stalls     (perf_load_stalls),
    .perf_flush_cycles    (perf_flush_cycles),
    .perf_mem_wait_cycles (perf_mem_wait_cycles)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_uses_rs2 = 1'b0; ex_rd = 5'd0;
    ex_mem_read = 1'b0; ex_redirect = 1'b0; dmem_req = 1'b0; dmem_ready = 1'b0;
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_RST) begin $display("FAIL reset_outs got=%b exp=%b", outs, O_RST); n_bad++; end
    tick();
    reset = 1'b0;
    #2;
    n_cmp++;
    if (outs !== O_RUN) begin $display("FAIL reset_release got=%b exp=%b", outs, O_RUN); n_bad++; end
  endtask

  task automatic test_load_use();
    logic       mr[6]   = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [4:0] rd[6]   = '{5'd5, 5'd5, 5'd5, 5'd5, 5'd0, 5'd5};
    logic [4:0] rs1[6]  = '{5'd5, 5'd5, 5'd6, 5'd6, 5'd0, 5'd5};
    logic [4:0] rs2[6]  = '{5'd7, 5'd7, 5'd5, 5'd5, 5'd0, 5'd7};
    logic       use2[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    logic [5:0] exp[6]  = '{O_STALL, O_RUN, O_STALL, O_RUN, O_RUN, O_RUN};
    for (int i = 0; i < 6; i++) begin
      tick();
      idle();
      ex_mem_read = mr[i]; ex_rd = rd[i]; id_rs1 = rs1[i]; id_rs2 = rs2[i]; id_uses_rs2 = use2[i];
      #2;
      n_cmp++;
      if (outs !== exp[i]) begin $display("FAIL load_use[%0d] got=%b exp=%b", i, outs, exp[i]); n_bad++; end
    end
  endtask

  task automatic test_redirect();
    tick(); idle();
    ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; ex_redirect = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_FLUSH) begin $display("FAIL redir_over_lu got=%b exp=%b", outs, O_FLUSH); n_bad++; end
    tick(); idle();
    ex_redirect = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_FLUSH) begin $display("FAIL flush_extra got=%b exp=%b", outs, O_FLUSH); n_bad++; end
    tick(); idle();
    #2;
    n_cmp++;
    if (outs !== O_RUN) begin $display("FAIL flush_done got=%b exp=%b", outs, O_RUN); n_bad++; end
  endtask

  task automatic test_mem_wait();
    for (int i = 0; i < 3; i++) begin
      tick(); idle();
      dmem_req = 1'b1;
      #2;
      n_cmp++;
      if (outs !== O_FREEZE) begin $display("FAIL mw_hold[%0d] got=%b exp=%b", i, outs, O_FREEZE); n_bad++; end
    end
    tick(); idle();
    dmem_req = 1'b1; dmem_ready = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_RUN) begin $display("FAIL mw_release got=%b exp=%b", outs, O_RUN); n_bad++; end
    tick(); idle();
    #2;
    n_cmp++;
    if (outs !== O_RUN) begin $display("FAIL mw_after got=%b exp=%b", outs, O_RUN); n_bad++; end
  endtask

  task automatic test_wait_redirect();
    logic [5:0] exp[5] = '{O_FREEZE, O_FREEZE, O_FLUSH, O_FLUSH, O_RUN};
    logic       req[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    logic       rdy[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic       red[5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 5; i++) begin
      tick(); idle();
      dmem_req = req[i]; dmem_ready = rdy[i]; ex_redirect = red[i];
      #2;
      n_cmp++;
      if (outs !== exp[i]) begin $display("FAIL wait_redir[%0d] got=%b exp=%b", i, outs, exp[i]); n_bad++; end
    end
  endtask

  task automatic test_flush_stall();
    logic [5:0] exp[4] = '{O_FLUSH, O_FREEZE, O_FLUSH, O_RUN};
    logic       req[4] = '{1'b0, 1'b1, 1'b1, 1'b0};
    logic       rdy[4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic       red[4] = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int i = 0; i < 4; i++) begin
      tick(); idle();
      dmem_req = req[i]; dmem_ready = rdy[i]; ex_redirect = red[i];
      #2;
      n_cmp++;
      if (outs !== exp[i]) begin $display("FAIL flush_stall[%0d] got=%b exp=%b", i, outs, exp[i]); n_bad++; end
    end
  endtask

  task automatic test_reset_mid();
    tick(); idle();
    ex_redirect = 1'b1;
    tick(); idle();
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_RST) begin $display("FAIL rst_mid_flush got=%b exp=%b", outs, O_RST); n_bad++; end
    tick();
    reset = 1'b0;
    #2;
    n_cmp++;
    if (outs !== O_RUN) begin $display("FAIL rst_flush_release got=%b exp=%b", outs, O_RUN); n_bad++; end
    tick(); idle();
    dmem_req = 1'b1;
    tick();
    #1;
    reset = 1'b1;
    #1;
    n_cmp++;
    if (outs !== O_RST) begin $display("FAIL rst_mid_wait got=%b exp=%b", outs, O_RST); n_bad++; end
    tick(); idle();
    reset = 1'b0;
    #2;
    n_cmp++;
    if (outs !== O_RUN) begin $display("FAIL rst_wait_release got=%b exp=%b", outs, O_RUN); n_bad++; end
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 16; i++) begin
      tick(); idle();
      dmem_req = 1'b1;
      #2;
      n_cmp++;
      if (outs !== O_FREEZE) begin $display("FAIL to_wait[%0d] got=%b exp=%b", i, outs, O_FREEZE); n_bad++; end
    end
    tick();
    #2;
    n_cmp++;
    if (outs !== O_HALT) begin $display("FAIL to_halt got=%b exp=%b", outs, O_HALT); n_bad++; end
    for (int i = 0; i < 3; i++) begin
      tick(); idle();
      dmem_ready = 1'b1; ex_redirect = 1'b1;
      #2;
      n_cmp++;
      if (outs !== O_HALT) begin $display("FAIL halt_sticky[%0d] got=%b exp=%b", i, outs, O_HALT); n_bad++; end
    end
    tick(); idle();
    reset = 1'b1;
    #2;
    n_cmp++;
    if (outs !== O_RST) begin $display("FAIL halt_reset got=%b exp=%b", outs, O_RST); n_bad++; end
    tick();
    reset = 1'b0;
    #2;
    n_cmp++;
    if (outs !== O_RUN) begin $display("FAIL halt_release got=%b exp=%b", outs, O_RUN); n_bad++; end
  endtask

`ifdef HAZARD_PERF_EN
  task automatic test_perf();
    tick(); idle();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick(); idle();
      ex_mem_read = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3;
      tick(); idle();
    end
    tick(); idle();
    ex_redirect = 1'b1;
    tick(); idle();
    tick(); idle();
    for (int i = 0; i < 3; i++) begin
      tick(); idle();
      dmem_req = 1'b1;
    end
    tick(); idle();
    dmem_req = 1'b1; dmem_ready = 1'b1;
    tick(); idle();
    tick();
    n_cmp++;
    if (perf_load_stalls !== 32'd2) begin $display("FAIL perf_load got=%0d exp=2", perf_load_stalls); n_bad++; end
    n_cmp++;
    if (perf_flush_cycles !== 32'd2) begin $display("FAIL perf_flush got=%0d exp=2", perf_flush_cycles); n_bad++; end
    n_cmp++;
    if (perf_mem_wait_cycles !== 32'd3) begin $display("FAIL perf_wait got=%0d exp=3", perf_mem_wait_cycles); n_bad++; end
  endtask
`endif

  initial begin
    test_reset();
    test_load_use();
    test_redirect();
    test_mem_wait();
    test_wait_redirect();
    test_flush_stall();
    test_reset_mid();
    test_timeout();
`ifdef HAZARD_PERF_EN
    test_perf();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
